// File: rtl/astat_reg_if.sv
// Universal-register port used by the register file
// to read and write ASTAT and STKY.
interface astat_reg_if #(
    parameter int DW = 16
);
    logic          ureg_wr_en;
    logic          ureg_wr_sel;
    logic [DW-1:0] ureg_wdata;
    logic          ureg_rd_sel;
    logic [DW-1:0] ureg_rdata;

    modport master (
        output ureg_wr_en,
        output ureg_wr_sel,
        output ureg_wdata,
        output ureg_rd_sel,
        input  ureg_rdata
    );

    modport slave (
        input  ureg_wr_en,
        input  ureg_wr_sel,
        input  ureg_wdata,
        input  ureg_rd_sel,
        output ureg_rdata
    );
endinterface

// File: rtl/astat_reg.sv
// Arithmetic status (ASTAT), sticky status (STKY)
// and the ASTAT push/pop stack for the sequencer.
module astat_reg #(
    parameter int STK_DEPTH = 4,
    parameter int DW        = 16,
    localparam int DEPTH_W  = $clog2(STK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_en,
    input  logic [3:0]         alu_flg,
    input  logic               mul_en,
    input  logic [1:0]         mul_flg,
    input  logic               shf_en,
    input  logic [1:0]         shf_flg,
    astat_reg_if.slave         ureg,
    input  logic               sts_push,
    input  logic               sts_pop,
    output logic [7:0]         astat_bts,
    output logic [4:0]         stky_bts,
    output logic [DEPTH_W-1:0] sts_depth,
    output logic               sts_full,
    output logic               sts_empty
);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [7:0]         astat_q, astat_d;
    logic [4:0]         stky_q, stky_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [7:0]         stk_q [STK_DEPTH];

    logic               push_ok, pop_ok, sso_set, ssu_set;
    logic               wr_astat, wr_stky;
    logic [IDX_W-1:0]   top_idx, wr_idx;

    assign sts_full  = (depth_q == DEPTH_W'(STK_DEPTH));
    assign sts_empty = (depth_q == '0);
    assign sts_depth = depth_q;
    assign astat_bts = astat_q;
    assign stky_bts  = stky_q;

    assign top_idx = IDX_W'(depth_q - 1'b1);
    assign wr_idx  = IDX_W'(depth_q);

    // A simultaneous push and pop cancels out entirely
    assign push_ok = sts_push & ~sts_pop & ~sts_full;
    assign pop_ok  = sts_pop & ~sts_push & ~sts_empty;
    assign sso_set = sts_push & ~sts_pop & sts_full;
    assign ssu_set = sts_pop & ~sts_push & sts_empty;

    assign wr_astat = ureg.ureg_wr_en & ~ureg.ureg_wr_sel;
    assign wr_stky  = ureg.ureg_wr_en & ureg.ureg_wr_sel;

    assign ureg.ureg_rdata = ureg.ureg_rd_sel ? DW'(stky_q)
                                              : DW'(astat_q);

    always_comb begin
        astat_d = astat_q;
        if (alu_en) astat_d[3:0] = alu_flg;
        if (mul_en) astat_d[5:4] = mul_flg;
        if (shf_en) astat_d[7:6] = shf_flg;
        if (pop_ok) astat_d = stk_q[top_idx];
        if (wr_astat) astat_d = ureg.ureg_wdata[7:0];
    end

    always_comb begin
        stky_d = stky_q | {ssu_set, sso_set,
                           shf_en & shf_flg[0],
                           mul_en & mul_flg[1],
                           alu_en & alu_flg[1]};
        if (wr_stky) stky_d = ureg.ureg_wdata[4:0];
    end

    always_comb begin
        depth_d = depth_q;
        if (push_ok) depth_d = depth_q + 1'b1;
        if (pop_ok)  depth_d = depth_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            astat_q <= '0;
            stky_q  <= '0;
            depth_q <= '0;
            for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            astat_q <= astat_d;
            stky_q  <= stky_d;
            depth_q <= depth_d;
            if (push_ok) stk_q[wr_idx] <= astat_q;
        end
    end
endmodule

// File: tb/tb_astat_reg.sv
// Directed self-checking bench for astat_reg.
// Each task drives one scenario and checks inline.
module tb_astat_reg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_en = 1'b0;
    logic [3:0] alu_flg = '0;
    logic       mul_en = 1'b0;
    logic [1:0] mul_flg = '0;
    logic       shf_en = 1'b0;
    logic [1:0] shf_flg = '0;
    logic       sts_push = 1'b0;
    logic       sts_pop = 1'b0;
    logic [7:0] astat_bts;
    logic [4:0] stky_bts;
    logic [2:0] sts_depth;
    logic       sts_full, sts_empty;

    int n_checks = 0;
    int n_fail = 0;

    astat_reg_if #(.DW(16)) ureg_bus ();

    astat_reg #(.STK_DEPTH(4), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_en    (alu_en),
        .alu_flg   (alu_flg),
        .mul_en    (mul_en),
        .mul_flg   (mul_flg),
        .shf_en    (shf_en),
        .shf_flg   (shf_flg),
        .ureg      (ureg_bus.slave),
        .sts_push  (sts_push),
        .sts_pop   (sts_pop),
        .astat_bts (astat_bts),
        .stky_bts  (stky_bts),
        .sts_depth (sts_depth),
        .sts_full  (sts_full),
        .sts_empty (sts_empty)
    );

    always #5 clk = ~clk;

    task automatic idle();
        alu_en = 0; mul_en = 0; shf_en = 0;
        sts_push = 0; sts_pop = 0;
        ureg_bus.ureg_wr_en = 0;
        ureg_bus.ureg_wr_sel = 0;
        ureg_bus.ureg_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr_astat(input logic [7:0] v);
        ureg_bus.ureg_wr_en = 1;
        ureg_bus.ureg_wr_sel = 0;
        ureg_bus.ureg_wdata = {8'h00, v};
    endtask

    task automatic wr_stky(input logic [4:0] v);
        ureg_bus.ureg_wr_en = 1;
        ureg_bus.ureg_wr_sel = 1;
        ureg_bus.ureg_wdata = {11'h0, v};
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #2 rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        ureg_bus.ureg_rd_sel = 0;
        rst_n = 0;
        #3;
        n_checks++;
        if (astat_bts !== 8'h00 || stky_bts !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_regs: astat=%h stky=%h need 00/00",
                     astat_bts, stky_bts);
        end
        n_checks++;
        if (sts_depth !== 3'd0 || sts_empty !== 1'b1 || sts_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stack: depth=%0d empty=%b full=%b need 0/1/0",
                     sts_depth, sts_empty, sts_full);
        end
        n_checks++;
        if (ureg_bus.ureg_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h need 0000",
                     ureg_bus.ureg_rdata);
        end
        #4 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_field_isolation();
        alu_en = 1; alu_flg = 4'b0101;
        shf_en = 1; shf_flg = 2'b10;
        tick();
        n_checks++;
        if (astat_bts !== 8'h85) begin
            n_fail++;
            $display("FAIL field_alu_shf: got %h need 85", astat_bts);
        end
        mul_en = 1; mul_flg = 2'b10;
        tick();
        n_checks++;
        if (astat_bts !== 8'hA5 || stky_bts !== 5'h02) begin
            n_fail++;
            $display("FAIL field_mul: astat=%h stky=%h need A5/02",
                     astat_bts, stky_bts);
        end
        ureg_bus.ureg_rd_sel = 0;
        #1;
        n_checks++;
        if (ureg_bus.ureg_rdata !== 16'h00A5) begin
            n_fail++;
            $display("FAIL rd_astat: got %h need 00A5",
                     ureg_bus.ureg_rdata);
        end
    endtask

    task automatic test_reset_midstream();
        sts_push = 1; tick();
        sts_push = 1; tick();
        n_checks++;
        if (sts_depth !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_depth: got %0d need 2", sts_depth);
        end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (astat_bts !== 8'h00 || stky_bts !== 5'h00 ||
            sts_depth !== 3'd0 || sts_empty !== 1'b1 ||
            ureg_bus.ureg_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: astat=%h stky=%h depth=%0d empty=%b need 00/00/0/1",
                     astat_bts, stky_bts, sts_depth, sts_empty);
        end
        #1 rst_n = 1;
    endtask

    task automatic test_priority();
        wr_astat(8'hFF); tick();
        sts_push = 1; tick();
        wr_astat(8'h3C);
        sts_pop = 1;
        alu_en = 1; alu_flg = 4'hF;
        #1;
        n_checks++;
        if (ureg_bus.ureg_rdata !== 16'h00FF) begin
            n_fail++;
            $display("FAIL rd_no_bypass: got %h need 00FF",
                     ureg_bus.ureg_rdata);
        end
        tick();
        n_checks++;
        if (astat_bts !== 8'h3C || sts_depth !== 3'd0 ||
            stky_bts !== 5'h01) begin
            n_fail++;
            $display("FAIL priority: astat=%h depth=%0d stky=%h need 3C/0/01",
                     astat_bts, sts_depth, stky_bts);
        end
    endtask

    task automatic test_stack();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22;
        vals[2] = 8'h33; vals[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_astat(vals[i]); tick();
            sts_push = 1; tick();
        end
        n_checks++;
        if (sts_full !== 1'b1 || sts_depth !== 3'd4) begin
            n_fail++;
            $display("FAIL stack_full: full=%b depth=%0d need 1/4",
                     sts_full, sts_depth);
        end
        sts_push = 1; tick();
        n_checks++;
        if (sts_depth !== 3'd4 || stky_bts !== 5'h08) begin
            n_fail++;
            $display("FAIL overflow: depth=%0d stky=%h need 4/08",
                     sts_depth, stky_bts);
        end
        for (int i = 0; i < 4; i++) begin
            sts_pop = 1; tick();
            n_checks++;
            if (astat_bts !== vals[3-i]) begin
                n_fail++;
                $display("FAIL pop_%0d: got %h need %h",
                         i, astat_bts, vals[3-i]);
            end
        end
        sts_pop = 1; tick();
        n_checks++;
        if (astat_bts !== 8'h11 || sts_depth !== 3'd0 ||
            sts_empty !== 1'b1 || stky_bts !== 5'h18) begin
            n_fail++;
            $display("FAIL underflow: astat=%h depth=%0d stky=%h need 11/0/18",
                     astat_bts, sts_depth, stky_bts);
        end
    endtask

    task automatic test_push_restore();
        sts_push = 1;
        alu_en = 1; alu_flg = 4'h2;
        tick();
        n_checks++;
        if (astat_bts !== 8'h12 || sts_depth !== 3'd1) begin
            n_fail++;
            $display("FAIL push_update: astat=%h depth=%0d need 12/1",
                     astat_bts, sts_depth);
        end
        sts_pop = 1; tick();
        n_checks++;
        if (astat_bts !== 8'h11) begin
            n_fail++;
            $display("FAIL restore: got %h need 11", astat_bts);
        end
    endtask

    task automatic test_simul_push_pop();
        wr_stky(5'h00); tick();
        sts_push = 1; tick();
        sts_push = 1; tick();
        sts_push = 1; sts_pop = 1; tick();
        n_checks++;
        if (sts_depth !== 3'd2 || astat_bts !== 8'h11 ||
            stky_bts !== 5'h00) begin
            n_fail++;
            $display("FAIL push_pop_same: depth=%0d astat=%h stky=%h need 2/11/00",
                     sts_depth, astat_bts, stky_bts);
        end
        wr_stky(5'h00);
        alu_en = 1; alu_flg = 4'b0010;
        tick();
        n_checks++;
        if (stky_bts !== 5'h00 || astat_bts !== 8'h12) begin
            n_fail++;
            $display("FAIL stky_write_wins: stky=%h astat=%h need 00/12",
                     stky_bts, astat_bts);
        end
        wr_stky(5'h15); tick();
        ureg_bus.ureg_rd_sel = 1;
        #1;
        n_checks++;
        if (ureg_bus.ureg_rdata !== 16'h0015) begin
            n_fail++;
            $display("FAIL rd_stky: got %h need 0015",
                     ureg_bus.ureg_rdata);
        end
        ureg_bus.ureg_rd_sel = 0;
    endtask

    initial begin
        test_reset();
        test_field_isolation();
        test_reset_midstream();
        test_priority();
        test_stack();
        test_push_restore();
        test_simul_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/astat_reg.md
# astat_reg

Arithmetic status register block for the program sequencer. It captures the ALU, multiplier and shifter flags into the 8-bit ASTAT register and drives `astat_bts` to the condition decoder. It also keeps a sticky-status (STKY) register and a small ASTAT push/pop stack for interrupt and `PUSH STS`/`POP STS` entry and exit. The register file reads and writes both registers through the universal-register port.

## Interface
- `STK_DEPTH`, default 4: number of status-stack entries (2..8).
- `DW`, default 16: universal-register data width (at least 8).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `alu_en`  in  1  ALU result valid this cycle; updates ASTAT[3:0].
- `alu_flg`  in  4  {ac, an, av, az}.
- `mul_en`  in  1  multiplier result valid; updates ASTAT[5:4].
- `mul_flg`  in  2  {mv, ms}.
- `shf_en`  in  1  shifter result valid; updates ASTAT[7:6].
- `shf_flg`  in  2  {sz, sv}.
- `ureg_wr_en`  in  1  universal-register write strobe.
- `ureg_wr_sel`  in  1  write target: 0 = ASTAT, 1 = STKY.
- `ureg_wdata`  in  DW  write data; ASTAT uses [7:0], STKY uses [4:0].
- `ureg_rd_sel`  in  1  read source: 0 = ASTAT, 1 = STKY.
- `ureg_rdata`  out  DW  combinational read of the selected register, zero-extended.
- `sts_push`  in  1  push the current ASTAT onto the status stack.
- `sts_pop`  in  1  pop the top entry into ASTAT.
- `astat_bts`  out  8  registered ASTAT: [0] az, [1] av, [2] an, [3] ac, [4] ms, [5] mv, [6] sv, [7] sz.
- `stky_bts`  out  5  [0] aos, [1] mos, [2] sos, [3] sso (stack overflow), [4] ssu (stack underflow).
- `sts_depth`  out  $clog2(STK_DEPTH+1)  current stack occupancy.
- `sts_full`  out  1  high when `sts_depth == STK_DEPTH`.
- `sts_empty`  out  1  high when `sts_depth == 0`.

## Operation
- **ASTAT next-state priority, highest first:**
  1. `ureg_wr_en && ureg_wr_sel == 0`: ASTAT loads `ureg_wdata[7:0]`; all compute updates and any pop restore are discarded.
  2. Valid pop: ASTAT loads the stack top. Compute updates in the same cycle are discarded.
  3. Compute update: each enabled unit overwrites only its own bit field. Fields of disabled units hold their value.
- **STKY:**
  - `aos`, `mos` and `sos` OR in `av`, `mv` and `sv` whenever the matching `*_en` is high. This happens even when the ASTAT update is discarded.
  - `sso` and `ssu` are set by the stack error conditions below.
  - A STKY ureg write replaces all 5 bits and wins over every set source in the same cycle.
  - Bits never self-clear.
- **Status stack:** LIFO of `STK_DEPTH` 8-bit entries.
  - Push stores the ASTAT value from *before* this cycle's update.
  - Push when `sts_full`: the entry is dropped, depth is unchanged, `sso` is set.
  - Pop when `sts_empty`: ASTAT is not restored (normal priority applies), depth stays 0, `ssu` is set.
  - `sts_push` and `sts_pop` in the same cycle: no stack change, no ASTAT restore, no error bit. Compute and ureg updates proceed normally.
- `ureg_rdata` returns the registered value, not the value being written this cycle.

## Timing
- **Reset (async, `rst_n` = 0):**
  - ASTAT, STKY, depth and all stack entries go to 0.
  - Outputs: `astat_bts` = 8'h00, `stky_bts` = 5'h00, `sts_depth` = 0, `sts_empty` = 1, `sts_full` = 0, `ureg_rdata` = 0.
  - Reset during any operation aborts it; no partial push or pop survives.
- **Latency:**
  - A flag presented with `*_en` in cycle N appears on `astat_bts` after the edge ending cycle N, so the condition decoder sees it in cycle N+1. There is no bypass path.
  - Push, pop, ureg writes and sticky updates all have the same one-cycle latency.
- **Status signals:** `sts_full`, `sts_empty` and `sts_depth` are registered state, decoded combinationally from depth.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with depth 2 and ASTAT = 8'hA5 -> all outputs 0 and `sts_empty` = 1 immediately, without waiting for a clock edge.
- **Field isolation:**
  - From ASTAT = 8'h00, apply `alu_en` = 1, `alu_flg` = 4'b0101 and `shf_en` = 1, `shf_flg` = 2'b10 in one cycle -> next cycle `astat_bts` = 8'h85. Bits [5:4] are unchanged.
  - From that state, apply `mul_en` = 1 with `mul_flg` = 2'b10 -> `astat_bts` = 8'hA5 and `stky_bts[1]` = 1.
- **Priority:** in one cycle, ureg write to ASTAT with 8'h3C, `sts_pop` = 1 (depth 1, top 8'hFF) and `alu_en` = 1 with `alu_flg` = 4'hF -> `astat_bts` = 8'h3C, depth 0, `aos` = 1.
- **Stack push/pop:**
  - With STK_DEPTH = 4, push 4 distinct values -> `sts_full` = 1.
  - A fifth push -> depth stays 4 and `sso` = 1.
  - 4 pops -> values return in reverse order.
  - A fifth pop -> `ssu` = 1 and ASTAT is unchanged.
- **Push then restore:** with ASTAT = 8'h11, assert `sts_push` and `alu_en` (`alu_flg` = 4'h2) in the same cycle -> `astat_bts` = 8'h12. A later pop restores 8'h11.
- **Simultaneous push/pop:** at depth 2, assert `sts_push` and `sts_pop` together -> depth 2, ASTAT and STKY unchanged. Then write STKY = 5'h00 while `av` = 1 -> `stky_bts` = 0.
